ccip_line_throttle: RTL and testbench

CCIP_LINE_THROTTLE -- requirements
Module: ccip_line_throttle

---
 rtl/ccip_line_throttle.sv | 151 +++++++++++++++
 tb/tb_ccip_line_throttle.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ccip_line_throttle.sv
// Per-VC CCI-P read line throttle with drain handshake and sticky error flags.
// Define CCIP_LINE_THROTTLE_STATS_EN to add the stall_cycles statistics counter.
module ccip_line_throttle #(
  parameter int NUM_VC    = 4,
  parameter int MAX_LINES = 256,
  parameter int CNT_W     = 10,
  localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  input  logic [VC_W-1:0]         req_vc,
  input  logic [1:0]              req_len,
  output logic                    req_ready,
  input  logic                    rsp_valid,
  input  logic [VC_W-1:0]         rsp_vc,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic [NUM_VC*CNT_W-1:0] active_lines,
  output logic [1:0]              err_flags
`ifdef CCIP_LINE_THROTTLE_STATS_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [CW1-1:0] MAX_W = CW1'(MAX_LINES);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                       state;
  logic [NUM_VC-1:0][CNT_W-1:0] cnt;
  logic [NUM_VC-1:0][CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0]             cur_cnt;
  logic                         vc_ok;
  logic [CW1-1:0]               sum;
  logic [CW1-1:0]               tmp;
  logic [CW1-1:0]               inc;
  logic                         accept;
  logic                         underflow;
  logic                         all_zero;

  // cl_len encoding: 0 -> 1 line, 1 -> 2 lines, 3 -> 4 lines; 2 is illegal.
  function automatic logic [2:0] len_lines(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd3:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Select the requesting VC's count without indexing past NUM_VC.
  always_comb begin
    cur_cnt = '0;
    vc_ok   = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (req_vc == VC_W'(v)) begin
        cur_cnt = cnt[v];
        vc_ok   = 1'b1;
      end
    end
  end

  assign sum       = {1'b0, cur_cnt} + CW1'(len_lines(req_len));
  assign req_ready = reset_n && (state == RUN) && (req_len != 2'd2) && vc_ok && (sum <= MAX_W);
  assign accept    = req_valid && req_ready;
  assign all_zero  = (cnt == '0);

  // A response on an empty VC only raises underflow when no acceptance offsets it.
  always_comb begin
    cnt_next  = cnt;
    underflow = 1'b0;
    tmp       = '0;
    inc       = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      inc = (accept && (req_vc == VC_W'(v))) ? CW1'(len_lines(req_len)) : '0;
      tmp = {1'b0, cnt[v]} + inc;
      if (rsp_valid && (rsp_vc == VC_W'(v))) begin
        if (tmp == '0) begin
          underflow = 1'b1;
        end else begin
          tmp = tmp - CW1'(1);
        end
      end
      cnt_next[v] = tmp[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      err_flags <= '0;
    end else begin
      cnt <= cnt_next;
      if (underflow) begin
        err_flags[0] <= 1'b1;
      end
      if (req_valid && (req_len == 2'd2)) begin
        err_flags[1] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RUN;
      drain_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (drain_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (all_zero) begin
            state      <= DONE;
            drain_done <= 1'b1;
          end else if (!drain_req) begin
            state <= RUN;
          end
        end
        DONE: begin
          if (!drain_req) begin
            state      <= RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

  assign active_lines = cnt;

`ifdef CCIP_LINE_THROTTLE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (req_valid && !req_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccip_line_throttle.sv
// Directed-vector bench for ccip_line_throttle (NUM_VC=3, MAX_LINES=8, CNT_W=4).
// Checks stall_cycles too when CCIP_LINE_THROTTLE_STATS_EN is defined.
module tb_ccip_line_throttle;
  localparam int NUM_VC    = 3;
  localparam int MAX_LINES = 8;
  localparam int CNT_W     = 4;
  localparam int VC_W      = 2;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    req_valid = 1'b0;
  logic [VC_W-1:0]         req_vc = '0;
  logic [1:0]              req_len = '0;
  logic                    req_ready;
  logic                    rsp_valid = 1'b0;
  logic [VC_W-1:0]         rsp_vc = '0;
  logic                    drain_req = 1'b0;
  logic                    drain_done;
  logic [NUM_VC*CNT_W-1:0] active_lines;
  logic [1:0]              err_flags;
`ifdef CCIP_LINE_THROTTLE_STATS_EN
  logic [31:0]             stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  ccip_line_throttle #(
    .NUM_VC(NUM_VC), .MAX_LINES(MAX_LINES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_vc(req_vc), .req_len(req_len), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_vc(rsp_vc),
    .drain_req(drain_req), .drain_done(drain_done),
    .active_lines(active_lines), .err_flags(err_flags)
`ifdef CCIP_LINE_THROTTLE_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [1:0]  vc;
    logic [1:0]  len;
    logic        rsp;
    logic [1:0]  rvc;
    logic        drain;
    logic        exp_ready;
    logic [11:0] exp_active;
    logic [1:0]  exp_err;
    logic        exp_done;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] vc, input logic [1:0] len,
                              input logic rs, input logic [1:0] rvc, input logic d, input logic er,
                              input logic [11:0] ea, input logic [1:0] ee, input logic ed, input string nm);
    vec_t t;
    t.rst_n = r; t.valid = v; t.vc = vc; t.len = len; t.rsp = rs; t.rvc = rvc; t.drain = d;
    t.exp_ready = er; t.exp_active = ea; t.exp_err = ee; t.exp_done = ed; t.name = nm;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t t);
    reset_n   = t.rst_n;
    req_valid = t.valid;
    req_vc    = t.vc;
    req_len   = t.len;
    rsp_valid = t.rsp;
    rsp_vc    = t.rvc;
    drain_req = t.drain;
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] vc, input logic [1:0] len,
                       input logic rs, input logic [1:0] rvc, input logic d);
    reset_n = r; req_valid = v; req_vc = vc; req_len = len; rsp_valid = rs; rsp_vc = rvc; drain_req = d;
  endtask

  initial begin
    int  waited;
    logic got_done;

    //            rst v vc len rsp rvc drn | rdy active  err  done
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 12'h000, 2'b00, 0, "reset"));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,    1, 12'h000, 2'b00, 0, "idle_after_reset"));
    vq.push_back(mk(1, 1, 1, 3, 0, 0, 0,    1, 12'h040, 2'b00, 0, "fill_vc1_a"));
    vq.push_back(mk(1, 1, 1, 3, 0, 0, 0,    1, 12'h080, 2'b00, 0, "fill_vc1_to_limit"));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 0,    0, 12'h080, 2'b00, 0, "vc1_full_blocks"));
    vq.push_back(mk(1, 1, 3, 0, 0, 0, 0,    0, 12'h080, 2'b00, 0, "vc_out_of_range"));
    vq.push_back(mk(1, 0, 0, 0, 1, 1, 0,    1, 12'h070, 2'b00, 0, "rsp_vc1"));
    vq.push_back(mk(1, 1, 0, 3, 0, 0, 0,    1, 12'h074, 2'b00, 0, "vc0_len4_a"));
    vq.push_back(mk(1, 1, 0, 3, 0, 0, 0,    1, 12'h078, 2'b00, 0, "vc0_len4_b"));
    vq.push_back(mk(1, 1, 0, 0, 1, 0, 0,    0, 12'h077, 2'b00, 0, "full_req_plus_rsp"));
    vq.push_back(mk(1, 1, 0, 0, 1, 0, 0,    1, 12'h077, 2'b00, 0, "same_cycle_net_zero"));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0,    1, 12'h078, 2'b00, 0, "reach_exact_max"));
    vq.push_back(mk(1, 0, 2, 0, 1, 2, 0,    1, 12'h078, 2'b01, 0, "underflow_vc2"));
    vq.push_back(mk(1, 0, 2, 3, 0, 0, 0,    1, 12'h078, 2'b01, 0, "underflow_sticky"));
    vq.push_back(mk(1, 1, 2, 2, 0, 0, 0,    0, 12'h078, 2'b11, 0, "illegal_len"));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 12'h000, 2'b00, 0, "reset_mid_run"));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 0,    1, 12'h001, 2'b00, 0, "vc0_one"));
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0,    1, 12'h003, 2'b00, 0, "vc0_three"));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1,    1, 12'h003, 2'b00, 0, "drain_enter"));
    vq.push_back(mk(1, 1, 0, 0, 1, 0, 1,    0, 12'h002, 2'b00, 0, "drain_blocks_rsp1"));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 1,    0, 12'h001, 2'b00, 0, "drain_rsp2"));
    vq.push_back(mk(1, 0, 0, 0, 1, 0, 1,    0, 12'h000, 2'b00, 0, "drain_rsp3"));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1,    0, 12'h000, 2'b00, 1, "drain_done_rises"));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1,    0, 12'h000, 2'b00, 1, "drain_done_held"));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,    0, 12'h000, 2'b00, 0, "done_exit"));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,    1, 12'h000, 2'b00, 0, "run_again"));
    vq.push_back(mk(1, 1, 2, 3, 0, 0, 1,    1, 12'h400, 2'b00, 0, "accept_as_drain_rises"));
    vq.push_back(mk(1, 0, 2, 3, 0, 0, 0,    0, 12'h400, 2'b00, 0, "drain_abort"));
    vq.push_back(mk(1, 1, 2, 3, 0, 0, 0,    1, 12'h800, 2'b00, 0, "run_after_abort"));
    vq.push_back(mk(1, 0, 0, 0, 1, 2, 0,    1, 12'h700, 2'b00, 0, "rsp_vc2"));

    @(negedge clk);
    foreach (vq[i]) begin
      apply_stimulus(vq[i]);
      #1;
      check_output({vq[i].name, ".req_ready"}, 32'(req_ready), 32'(vq[i].exp_ready));
      @(posedge clk);
      #1;
      check_output({vq[i].name, ".active_lines"}, 32'(active_lines), 32'(vq[i].exp_active));
      check_output({vq[i].name, ".err_flags"}, 32'(err_flags), 32'(vq[i].exp_err));
      check_output({vq[i].name, ".drain_done"}, 32'(drain_done), 32'(vq[i].exp_done));
      @(negedge clk);
    end

    // Fill VC1 one line at a time up to the limit.
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < MAX_LINES; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0);
      #1;
      check_output($sformatf("step_fill_%0d.req_ready", i), 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      check_output($sformatf("step_fill_%0d.active1", i), 32'(active_lines[7:4]), 32'(i + 1));
      @(negedge clk);
    end
    drive(1, 1, 1, 0, 0, 0, 0);
    #1;
    check_output("step_fill_full.req_ready", 32'(req_ready), 32'd0);

    // Drain all eight lines, then wait a bounded time for drain_done.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    for (int i = 0; i < MAX_LINES; i++) begin
      drive(1, 0, 0, 0, 1, 1, 1);
      @(negedge clk);
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    check_output("drain8.active_lines", 32'(active_lines), 32'h000);
    got_done = 1'b0;
    waited   = 0;
    while (!got_done && waited < 4) begin
      @(posedge clk);
      #1;
      got_done = drain_done;
      waited++;
    end
    check_output("drain8.drain_done_seen", 32'(got_done), 32'd1);
    check_output("drain8.latency", 32'(waited), 32'd1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_output("drain8.exit_done", 32'(drain_done), 32'd0);
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 0, 0);
    #1;
    check_output("drain8.ready_again", 32'(req_ready), 32'd1);
    @(negedge clk);

`ifdef CCIP_LINE_THROTTLE_STATS_EN
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_output("stats.reset", stall_cycles, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 2, 0, 0, 0);
      @(negedge clk);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("stats.stall_cycles", stall_cycles, 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
